gcd_request_sequencer: RTL and testbench

- Initiator side of the GCD engine's start/done protocol: accepts operand pairs on a valid/ready input, serialises them onto the engine's shared data bus (A then B), waits for done, captures the result and returns it on a valid/ready output.
- Handles zero operands locally, because the subtractive engine never terminates on zero.
- Clears the engine's sticky done between jobs and reports the engine cycle count per job.

---
 rtl/gcd_request_sequencer.sv | 168 ++++++++++++++++
 tb/tb_gcd_request_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_request_sequencer.sv
// gcd_request_sequencer: initiator side of the GCD engine start/done protocol.
// Takes operand pairs on a valid/ready input and drives the engine bus with A,
// then B. It waits for done, pulses eng_clear, and returns the result on a
// valid/ready output. Pairs with a zero operand are answered locally, because
// the subtractive engine never terminates on a zero operand.
// Optional build macro: GCD_SEQ_TIMEOUT_EN. It bounds the WAIT state to
// TIMEOUT_CYCLES and reports an expired bound on out_err.
module gcd_request_sequencer #(
    parameter int W              = 8,
    parameter int CW             = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_bypass,
    output logic          out_err,
    output logic [CW-1:0] out_cycles,
    output logic          eng_start,
    output logic [W-1:0]  eng_data,
    output logic          eng_clear,
    input  logic          eng_done,
    input  logic [W-1:0]  eng_result
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_CLEAR, S_RESP
    } state_t;

    // The timeout must be representable by the cycle counter.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**CW) - 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES does not fit in CW bits");
    end

    state_t        state_q, state_d;
    logic [W-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_bypass_q, out_bypass_d;
    logic          out_err_q, out_err_d;
    logic [CW-1:0] out_cycles_q, out_cycles_d;
    logic          eng_start_q, eng_start_d;
    logic [W-1:0]  eng_data_q, eng_data_d;
    logic          eng_clear_q, eng_clear_d;

    // The engine cycle counter saturates instead of wrapping.
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // Compute the next state and the next value of every registered output.
    always_comb begin
        state_d      = state_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_bypass_d = out_bypass_q;
        out_err_d    = out_err_q;
        out_cycles_d = out_cycles_q;
        eng_data_d   = eng_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    b_d       = in_b;
                    out_err_d = 1'b0;
                    if (in_a == '0 || in_b == '0) begin
                        // gcd(x,0) = x and gcd(0,0) = 0, so A|B is the answer.
                        out_data_d   = in_a | in_b;
                        out_bypass_d = 1'b1;
                        out_cycles_d = '0;
                        state_d      = S_RESP;
                    end else begin
                        eng_data_d = in_a;
                        cnt_d      = CW'(1);
                        state_d    = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: begin
                eng_data_d = b_q;
                cnt_d      = cnt_inc;
                state_d    = S_LOAD_B;
            end
            S_LOAD_B: begin
                cnt_d   = cnt_inc;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    out_data_d   = eng_result;
                    out_bypass_d = 1'b0;
                    out_cycles_d = cnt_q;
                    state_d      = S_CLEAR;
                end
`ifdef GCD_SEQ_TIMEOUT_EN
                else if (cnt_q >= CW'(TIMEOUT_CYCLES)) begin
                    out_err_d    = 1'b1;
                    out_data_d   = '0;
                    out_bypass_d = 1'b0;
                    out_cycles_d = CW'(TIMEOUT_CYCLES);
                    state_d      = S_CLEAR;
                end
`endif
                else begin
                    cnt_d = cnt_inc;
                end
            end
            S_CLEAR: state_d = S_RESP;
            S_RESP: begin
                if (out_valid_q && out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Registered Moore strobes follow the state being entered.
        in_ready_d  = (state_d == S_IDLE);
        eng_start_d = (state_d == S_LOAD_A);
        eng_clear_d = (state_d == S_CLEAR);
        out_valid_d = (state_d == S_RESP);
    end

    // State and output registers. Reset holds the engine in restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            b_q          <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_bypass_q <= 1'b0;
            out_err_q    <= 1'b0;
            out_cycles_q <= '0;
            eng_start_q  <= 1'b0;
            eng_data_q   <= '0;
            eng_clear_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_bypass_q <= out_bypass_d;
            out_err_q    <= out_err_d;
            out_cycles_q <= out_cycles_d;
            eng_start_q  <= eng_start_d;
            eng_data_q   <= eng_data_d;
            eng_clear_q  <= eng_clear_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_bypass = out_bypass_q;
    assign out_err    = out_err_q;
    assign out_cycles = out_cycles_q;
    assign eng_start  = eng_start_q;
    assign eng_data   = eng_data_q;
    assign eng_clear  = eng_clear_q;

endmodule

// File: tb/tb_gcd_request_sequencer.sv
// Bench for gcd_request_sequencer. It pairs the DUT with a behavioural
// subtractive engine and compares against Euclid's algorithm.
module tb_gcd_request_sequencer;
    localparam int W = 8, CW = 16, TO = 20;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic in_ready, out_valid, out_bypass, out_err, eng_start, eng_clear;
    logic [W-1:0] out_data, eng_data;
    logic [CW-1:0] out_cycles;
    logic eng_done = 1'b0;
    logic [W-1:0] eng_result = '0;

    int n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    gcd_request_sequencer #(.W(W), .CW(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_bypass(out_bypass), .out_err(out_err),
        .out_cycles(out_cycles), .eng_start(eng_start), .eng_data(eng_data),
        .eng_clear(eng_clear), .eng_done(eng_done), .eng_result(eng_result)
    );

    // Behavioural engine: load A on start, B the next cycle, subtract until equal.
    logic [W-1:0] ea = '0, eb = '0;
    int est = 0;
    bit never_done = 1'b0;
    always @(posedge clk) begin
        if (eng_clear) begin
            est <= 0; eng_done <= 1'b0;
        end else begin
            case (est)
                0: if (eng_start) begin ea <= eng_data; est <= 1; end
                1: begin eb <= eng_data; est <= 2; end
                2: if (!never_done) begin
                    if (ea == eb) begin eng_result <= ea; eng_done <= 1'b1; est <= 3; end
                    else if (ea > eb) ea <= ea - eb;
                    else eb <= eb - ea;
                end
                default: ;
            endcase
        end
    end

    // Bus monitor: strobe counts, loaded operands and cycles from start to done.
    int n_start = 0, n_clear = 0, m_cyc = 0, meas_cyc = 0, ready_viol = 0;
    bit counting = 1'b0, grab_b = 1'b0;
    logic [W-1:0] d_a = '0, d_b = '0;
    always @(negedge clk) begin
        if (eng_start) n_start++;
        if (eng_clear && rst_n) n_clear++;
        if (grab_b) begin d_b = eng_data; grab_b = 1'b0; end
        if (eng_start) begin
            d_a = eng_data; grab_b = 1'b1; m_cyc = 1; counting = 1'b1;
        end else if (counting) begin
            m_cyc++;
            if (eng_done) begin meas_cyc = m_cyc; counting = 1'b0; end
        end
        if (!rst_n || eng_clear) counting = 1'b0;
        if (in_ready && (out_valid || eng_start || eng_clear)) ready_viol++;
    end

    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin t = a % b; a = b; b = t; end
        return a;
    endfunction

    task automatic step;
        @(negedge clk); #1;
    endtask

    // Drive one job and collect its response. Comparisons are made by the callers.
    task automatic do_job(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          output logic [W-1:0] data, output logic byp, output logic err,
                          output logic [CW-1:0] cyc, output int lat, output bit stable,
                          output bit clr_before, output bit done_ok, output bit released);
        int t;
        bit prev_clr;
        done_ok = 0; stable = 1; released = 0; clr_before = 0; prev_clr = 0;
        data = '0; byp = 0; err = 0; cyc = '0;
        t = 0;
        while (!in_ready && t < 200) begin step; t++; end
        in_valid = 1; in_a = a; in_b = b;
        step;
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 600) begin prev_clr = eng_clear; step; lat++; end
        if (!out_valid) return;
        done_ok = 1; clr_before = prev_clr;
        data = out_data; byp = out_bypass; err = out_err; cyc = out_cycles;
        repeat (hold) begin
            step;
            if (!out_valid || out_data !== data || out_bypass !== byp || out_err !== err ||
                out_cycles !== cyc || in_ready) stable = 0;
        end
        out_ready = 1;
        step;
        out_ready = 0;
        released = !out_valid && in_ready;
    endtask

    logic [W-1:0] r_data;
    logic r_byp, r_err;
    logic [CW-1:0] r_cyc;
    int r_lat;
    bit r_stable, r_clr, r_ok, r_rel;

    task automatic test_reset;
        #12;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0 || out_cycles !== '0) $display("FAIL rst_out_data got %0d/%0d want 0/0", out_data, out_cycles); else n_pass++;
        n_checks++; if (out_bypass !== 1'b0 || out_err !== 1'b0) $display("FAIL rst_flags got byp=%0b err=%0b want 0/0", out_bypass, out_err); else n_pass++;
        n_checks++; if (eng_start !== 1'b0 || eng_data !== '0) $display("FAIL rst_eng_bus got start=%0b data=%0d want 0/0", eng_start, eng_data); else n_pass++;
        n_checks++; if (eng_clear !== 1'b1) $display("FAIL rst_eng_clear got %0b want 1", eng_clear); else n_pass++;
        step;
        rst_n = 1;
        step; step;
        n_checks++; if (in_ready !== 1'b1 || eng_clear !== 1'b0) $display("FAIL idle_after_reset got ready=%0b clear=%0b want 1/0", in_ready, eng_clear); else n_pass++;
    endtask

    task automatic test_basic;
        n_start = 0; n_clear = 0;
        do_job(8'd12, 8'd18, 0, r_data, r_byp, r_err, r_cyc, r_lat, r_stable, r_clr, r_ok, r_rel);
        n_checks++; if (!r_ok || r_data !== 8'd6) $display("FAIL basic_data got %0d (ok=%0b) want 6", r_data, r_ok); else n_pass++;
        n_checks++; if (r_byp !== 1'b0 || r_err !== 1'b0) $display("FAIL basic_flags got byp=%0b err=%0b want 0/0", r_byp, r_err); else n_pass++;
        n_checks++; if (n_start != 1 || d_a !== 8'd12 || d_b !== 8'd18) $display("FAIL basic_load got starts=%0d a=%0d b=%0d want 1/12/18", n_start, d_a, d_b); else n_pass++;
        n_checks++; if (n_clear != 1 || !r_clr) $display("FAIL basic_clear got pulses=%0d before_valid=%0b want 1/1", n_clear, r_clr); else n_pass++;
        n_checks++; if (r_cyc !== CW'(meas_cyc)) $display("FAIL basic_cycles got %0d want %0d", r_cyc, meas_cyc); else n_pass++;
        n_checks++; if (!r_rel) $display("FAIL basic_release got 0 want 1"); else n_pass++;
    endtask

    task automatic test_bypass;
        logic [W-1:0] pa [3];
        logic [W-1:0] pb [3];
        logic [W-1:0] ex [3];
        pa = '{8'd0, 8'd9, 8'd0}; pb = '{8'd7, 8'd0, 8'd0}; ex = '{8'd7, 8'd9, 8'd0};
        n_start = 0;
        for (int i = 0; i < 3; i++) begin
            do_job(pa[i], pb[i], 0, r_data, r_byp, r_err, r_cyc, r_lat, r_stable, r_clr, r_ok, r_rel);
            n_checks++; if (!r_ok || r_data !== ex[i] || r_byp !== 1'b1) $display("FAIL bypass_%0d got data=%0d byp=%0b want %0d/1", i, r_data, r_byp, ex[i]); else n_pass++;
            n_checks++; if (r_lat != 1 || r_cyc !== '0) $display("FAIL bypass_lat_%0d got lat=%0d cyc=%0d want 1/0", i, r_lat, r_cyc); else n_pass++;
        end
        n_checks++; if (n_start != 0) $display("FAIL bypass_no_start got %0d want 0", n_start); else n_pass++;
    endtask

    task automatic test_backpressure;
        do_job(8'd35, 8'd21, 5, r_data, r_byp, r_err, r_cyc, r_lat, r_stable, r_clr, r_ok, r_rel);
        n_checks++; if (!r_ok || r_data !== 8'd7 || r_cyc !== CW'(meas_cyc)) $display("FAIL bp_result got %0d/%0d want 7/%0d", r_data, r_cyc, meas_cyc); else n_pass++;
        n_checks++; if (!r_stable) $display("FAIL bp_stable got 0 want 1"); else n_pass++;
        n_checks++; if (!r_rel) $display("FAIL bp_release got 0 want 1"); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] pa [2];
        logic [W-1:0] pb [2];
        logic [W-1:0] ex [2];
        int sent, got, t;
        bit acc;
        pa = '{8'd48, 8'd17}; pb = '{8'd36, 8'd5}; ex = '{8'd12, 8'd1};
        sent = 0; got = 0; t = 0; ready_viol = 0;
        out_ready = 1; in_valid = 1; in_a = pa[0]; in_b = pb[0];
        while (got < 2 && t < 1000) begin
            acc = in_valid && in_ready;
            step; t++;
            if (out_valid) begin
                n_checks++; if (out_data !== ex[got]) $display("FAIL b2b_result_%0d got %0d want %0d", got, out_data, ex[got]); else n_pass++;
                got++;
            end
            if (acc) begin
                sent++;
                if (sent < 2) begin in_a = pa[sent]; in_b = pb[sent]; end
                else in_valid = 0;
            end
        end
        step;
        out_ready = 0; in_valid = 0;
        n_checks++; if (got != 2) $display("FAIL b2b_count got %0d want 2", got); else n_pass++;
        n_checks++; if (ready_viol != 0) $display("FAIL b2b_ready_idle got %0d violations want 0", ready_viol); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int t;
        bit saw;
        t = 0;
        while (!in_ready && t < 100) begin step; t++; end
        in_valid = 1; in_a = 8'd100; in_b = 8'd75;
        step;
        in_valid = 0;
        t = 0;
        while (!eng_start && t < 50) begin step; t++; end
        step; step;
        rst_n = 0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || eng_clear !== 1'b1) $display("FAIL midrst_ctrl got v=%0b r=%0b c=%0b want 0/0/1", out_valid, in_ready, eng_clear); else n_pass++;
        n_checks++; if (eng_start !== 1'b0 || eng_data !== '0 || out_data !== '0) $display("FAIL midrst_data got s=%0b d=%0d o=%0d want 0/0/0", eng_start, eng_data, out_data); else n_pass++;
        step; step;
        rst_n = 1;
        saw = 0;
        repeat (6) begin step; if (out_valid) saw = 1; end
        n_checks++; if (saw) $display("FAIL midrst_no_output got out_valid=1 want 0"); else n_pass++;
        do_job(8'd8, 8'd12, 0, r_data, r_byp, r_err, r_cyc, r_lat, r_stable, r_clr, r_ok, r_rel);
        n_checks++; if (!r_ok || r_data !== 8'd4) $display("FAIL midrst_next_job got %0d want 4", r_data); else n_pass++;
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        int ex;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom_range(0, 255));
            b = W'($urandom_range(0, 255));
            if (i % 6 == 1) a = '0;
            if (i % 6 == 4) b = '0;
            ex = gcd_ref(int'(a), int'(b));
            do_job(a, b, int'($urandom_range(0, 3)), r_data, r_byp, r_err, r_cyc, r_lat, r_stable, r_clr, r_ok, r_rel);
            n_checks++;
            if (!r_ok || r_data !== W'(ex) || r_byp !== (a == 0 || b == 0) || r_err !== 1'b0 || !r_stable || !r_rel)
                $display("FAIL rand_%0d (%0d,%0d) got data=%0d byp=%0b err=%0b want %0d", i, a, b, r_data, r_byp, r_err, ex);
            else n_pass++;
            n_checks++;
            if ((a == 0 || b == 0) ? (r_cyc !== '0 || r_lat != 1) : (r_cyc !== CW'(meas_cyc)))
                $display("FAIL rand_cycles_%0d got cyc=%0d lat=%0d want %0d", i, r_cyc, r_lat, (a == 0 || b == 0) ? 0 : meas_cyc);
            else n_pass++;
        end
    endtask

`ifdef GCD_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        never_done = 1; n_clear = 0;
        do_job(8'd12, 8'd18, 0, r_data, r_byp, r_err, r_cyc, r_lat, r_stable, r_clr, r_ok, r_rel);
        n_checks++; if (!r_ok || r_err !== 1'b1 || r_data !== '0 || r_byp !== 1'b0) $display("FAIL to_result got err=%0b data=%0d byp=%0b want 1/0/0", r_err, r_data, r_byp); else n_pass++;
        n_checks++; if (r_cyc !== CW'(TO) || n_clear != 1) $display("FAIL to_cycles got %0d clears=%0d want %0d/1", r_cyc, n_clear, TO); else n_pass++;
        never_done = 0;
        do_job(8'd8, 8'd12, 0, r_data, r_byp, r_err, r_cyc, r_lat, r_stable, r_clr, r_ok, r_rel);
        n_checks++; if (!r_ok || r_err !== 1'b0 || r_data !== 8'd4) $display("FAIL to_recover got err=%0b data=%0d want 0/4", r_err, r_data); else n_pass++;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_bypass;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_random;
`ifdef GCD_SEQ_TIMEOUT_EN
        test_timeout;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
